mar_ram: RTL and testbench

//  - Memory address register plus 16x8 program/data RAM. This is the consumer of the 4-bit ABUS driven by the program counter.
//  - Latches an address from ABUS and drives the addressed word onto the 8-bit WBUS.
//  - Includes a program-mode loader (valid/ready handshake) that fills the RAM before a run.
//  - Clears the RAM with a hardware sweep after every reset.

---
 rtl/sap1_pkg.sv | 21 ++
 rtl/ram_array.sv | 27 ++
 rtl/mar_ram.sv | 146 ++++++++++++++
 tb/tb_mar_ram.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared constants and FSM state type for the memory address register / RAM block.
// MAR_RAM_PARITY_EN adds one parity bit to each stored word.
package sap1_pkg;

  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 8;
  localparam int RAM_DEPTH = 2 ** AW_DEF;

`ifdef MAR_RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/ram_array.sv
// DEPTH x WW storage: one synchronous write port and one asynchronous read port.
module ram_array
  import sap1_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int WW    = DW_DEF + PAR_W,
  parameter int DEPTH = RAM_DEPTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mar_ram.sv
// Memory address register, 16x8 RAM with post-reset clear sweep and program-mode loader.
// Optional per-word parity checking is enabled by defining MAR_RAM_PARITY_EN.
module mar_ram
  import sap1_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic [AW-1:0] ABUS,
  input  logic          nLm,
  input  logic          nCE,
  output logic [DW-1:0] WBUS,
  input  logic          PROG,
  input  logic          PG_VALID,
  output logic          PG_READY,
  input  logic [AW-1:0] PG_ADDR,
  input  logic [DW-1:0] PG_DATA,
  output logic          BUSY,
  input  logic          PG_FLIP,
  output logic          PERR
);

  localparam int WW = DW + PAR_W;

  state_e        state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [WW-1:0] ram_wdata;
  logic [WW-1:0] ram_rdata;
  logic          read_en;

  assign read_en = (state_q == IDLE) && !PROG && !nCE;

`ifdef MAR_RAM_PARITY_EN
  logic flip_q, flip_d;
  logic perr_q, perr_d;
`else
  logic unused_flip;
  assign unused_flip = PG_FLIP;
`endif

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    mar_d     = mar_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    ram_we    = 1'b0;
    ram_waddr = sweep_q;
    ram_wdata = '0;
`ifdef MAR_RAM_PARITY_EN
    flip_d    = flip_q;
    perr_d    = perr_q | (read_en & (^ram_rdata));
`endif
    case (state_q)
      CLEAR: begin
        ram_we  = !CLR;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == {AW{1'b1}}) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (PROG) begin
          if (PG_VALID) begin
            waddr_d = PG_ADDR;
            wdata_d = PG_DATA;
`ifdef MAR_RAM_PARITY_EN
            flip_d  = PG_FLIP;
`endif
            state_d = WRITE;
          end
        end else if (!nLm) begin
          // Old MAR still addresses the read port this cycle; new address shows next cycle.
          mar_d = ABUS;
        end
      end
      WRITE: begin
        ram_we    = !CLR;
        ram_waddr = waddr_q;
`ifdef MAR_RAM_PARITY_EN
        ram_wdata = {(^wdata_q) ^ flip_q, wdata_q};
`else
        ram_wdata = wdata_q;
`endif
        state_d   = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= CLEAR;
      sweep_q <= '0;
      mar_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef MAR_RAM_PARITY_EN
      flip_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      mar_q   <= mar_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef MAR_RAM_PARITY_EN
      flip_q  <= flip_d;
      perr_q  <= perr_d;
`endif
    end
  end

  ram_array #(
    .AW   (AW),
    .WW   (WW),
    .DEPTH(2 ** AW)
  ) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(mar_q),
    .rdata(ram_rdata)
  );

  assign BUSY     = (state_q != IDLE);
  assign PG_READY = (state_q == IDLE) && PROG;
  assign WBUS     = read_en ? ram_rdata[DW-1:0] : {DW{1'bz}};

`ifdef MAR_RAM_PARITY_EN
  assign PERR = perr_q;
`else
  assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_mar_ram.sv
// Scoreboard bench for mar_ram: a per-cycle behavioural model queues expected outputs,
// a negedge monitor pops and compares them. A floating WBUS reads as 8'hFF (pulled-up net).
module tb_mar_ram;

  logic       clk = 1'b0;
  logic       clr, prog, pg_valid, nlm, nce, pg_flip;
  logic [3:0] abus, pg_addr;
  logic [7:0] pg_data;
  tri1  [7:0] wbus;
  logic       pg_ready, busy, perr;

  always #5 clk = ~clk;

  mar_ram dut (
    .CLK(clk), .CLR(clr), .ABUS(abus), .nLm(nlm), .nCE(nce), .WBUS(wbus),
    .PROG(prog), .PG_VALID(pg_valid), .PG_READY(pg_ready), .PG_ADDR(pg_addr),
    .PG_DATA(pg_data), .BUSY(busy), .PG_FLIP(pg_flip), .PERR(perr)
  );

  typedef struct {
    string      name;
    logic       busy;
    logic       ready;
    logic [7:0] wbus;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Behavioural model state
  logic [7:0] m_mem [16];
  bit         m_par [16];
  int         m_clear_left = 16;
  bit         m_pend = 0;
  logic [3:0] m_wa;
  logic [7:0] m_wd;
  bit         m_wf;
  logic [3:0] m_mar = 0;
  bit         m_perr = 0;
  bit         m_accepted;

  task automatic check_bit(input string nm, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, expv);
    end
  endtask

  task automatic check_byte(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_bit ({e.name, ".busy"},  busy,     e.busy);
      check_bit ({e.name, ".ready"}, pg_ready, e.ready);
      check_byte({e.name, ".wbus"},  wbus,     e.wbus);
      check_bit ({e.name, ".perr"},  perr,     e.perr);
      $display("chk %-10s busy=%b ready=%b wbus=%h perr=%b", e.name, busy, pg_ready, wbus, perr);
    end
  end

  // Evaluate one cycle with the inputs currently applied, then advance past the edge.
  task automatic cycle(input string name, input bit chk);
    exp_t e;
    bit   m_busy, rd;
    m_busy     = (m_clear_left > 0) || m_pend;
    rd         = !m_busy && !prog && !nce;
    m_accepted = !m_busy && prog && pg_valid && !clr;
    e.name  = name;
    e.busy  = m_busy;
    e.ready = !m_busy && prog;
    e.wbus  = rd ? m_mem[m_mar] : 8'hFF;
    e.perr  = m_perr;
    if (chk) exp_q.push_back(e);
    if (clr) begin
      m_clear_left = 16; m_pend = 0; m_mar = 0; m_perr = 0;
    end else if (m_clear_left > 0) begin
      m_mem[16 - m_clear_left] = 8'h00;
      m_par[16 - m_clear_left] = 1'b0;
      m_clear_left--;
    end else if (m_pend) begin
      m_mem[m_wa] = m_wd;
`ifdef MAR_RAM_PARITY_EN
      m_par[m_wa] = (^m_wd) ^ m_wf;
`else
      m_par[m_wa] = 1'b0;
`endif
      m_pend = 0;
    end else if (prog) begin
      if (pg_valid) begin
        m_pend = 1; m_wa = pg_addr; m_wd = pg_data; m_wf = pg_flip;
      end
    end else begin
`ifdef MAR_RAM_PARITY_EN
      if (rd && ((^m_mem[m_mar]) ^ m_par[m_mar])) m_perr = 1;
`endif
      if (!nlm) m_mar = abus;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] d, input bit f);
    bit done = 0;
    prog = 1; pg_valid = 1; pg_addr = a; pg_data = d; pg_flip = f;
    for (int i = 0; i < 8 && !done; i++) begin
      cycle("load", 1);
      done = m_accepted;
    end
    n_checks++;
    if (!done) begin
      n_err++;
      $display("FAIL load_timeout: got not-accepted expected accepted addr=%h", a);
    end
  endtask

  task automatic run_cycle(input string nm, input bit l, input bit c, input logic [3:0] a);
    prog = 0; pg_valid = 0; nlm = l; nce = c; abus = a;
    cycle(nm, 1);
  endtask

  task automatic do_reset(input bit chk);
    clr = 1; prog = 0; pg_valid = 0; nlm = 1; nce = 0;
    cycle("reset", chk);
    clr = 0;
  endtask

  initial begin
    clr = 1; prog = 0; pg_valid = 0; nlm = 1; nce = 0; pg_flip = 0;
    abus = 0; pg_addr = 0; pg_data = 0;
    cycle("pre", 0);
    do_reset(1);
    for (int i = 0; i < 16; i++) cycle("sweep", 1);
    for (int i = 0; i < 17; i++) run_cycle("zero_rd", 0, 0, 4'(i));

    // Directed loads, valid held high between words
    load_word(4'd3, 8'hA5, 0);
    load_word(4'd15, 8'h3C, 0);
    pg_valid = 0;
    cycle("load_end", 1);

    run_cycle("mar3", 0, 1, 4'd3);
    run_cycle("rd3", 1, 0, 4'd0);
    run_cycle("mar15", 0, 1, 4'd15);
    run_cycle("rd15", 1, 0, 4'd0);
    run_cycle("mar3b", 0, 1, 4'd3);
    run_cycle("simul", 0, 0, 4'd15);
    run_cycle("simul_nx", 1, 0, 4'd0);
    prog = 1; nce = 0; pg_valid = 0;
    cycle("gate", 1);

    // Continuous valid: every other cycle accepted
    pg_valid = 1;
    for (int i = 0; i < 6; i++) begin
      pg_addr = 4'($urandom_range(0, 15)); pg_data = 8'($urandom_range(0, 254));
      cycle("valid_hi", 1);
    end

    // Randomized mixed traffic
    for (int i = 0; i < 150; i++) begin
      prog     = ($urandom_range(0, 3) == 0);
      pg_valid = $urandom_range(0, 1) == 1;
      pg_addr  = 4'($urandom_range(0, 15));
      pg_data  = 8'($urandom_range(0, 254));
      pg_flip  = 0;
      nlm      = $urandom_range(0, 1) == 1;
      nce      = $urandom_range(0, 1) == 1;
      abus     = 4'($urandom_range(0, 15));
      cycle("rand", 1);
    end

    // CLR mid-sweep
    do_reset(1);
    for (int i = 0; i < 7; i++) cycle("sweep_a", 1);
    do_reset(1);
    for (int i = 0; i < 16; i++) cycle("sweep_b", 1);
    for (int i = 0; i < 17; i++) run_cycle("zero_rd2", 0, 0, 4'(i));

    // Parity: flipped parity on addr 5
    load_word(4'd5, 8'h01, 1);
    pg_valid = 0; pg_flip = 0;
    cycle("par_wr", 1);
    run_cycle("par_mar", 0, 1, 4'd5);
    run_cycle("par_rd", 1, 0, 4'd0);
    for (int i = 0; i < 4; i++) run_cycle("par_hold", 1, 1, 4'd0);
    do_reset(1);
    cycle("par_clr", 1);

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
